// File: rtl/dma_mmio_launcher_if.sv
// -----------------------------------------------------------------------------
// dma_mmio_launcher_if
// MMIO bus between a host-side initiator and the DMA AFU register block.
//   mmio_wr_en    write strobe, one cycle per write
//   mmio_wr_addr  16-bit write address
//   mmio_wr_data  64-bit write data
//   mmio_rd_en    read strobe, one cycle per read
//   mmio_rd_addr  16-bit read address
//   mmio_rd_data  64-bit read data, returned a fixed latency after mmio_rd_en
// Modports: master (initiator drives strobes/addresses/write data),
//           slave  (register block returns read data).
// -----------------------------------------------------------------------------
interface dma_mmio_launcher_if;
  logic        mmio_wr_en;
  logic [15:0] mmio_wr_addr;
  logic [63:0] mmio_wr_data;
  logic        mmio_rd_en;
  logic [15:0] mmio_rd_addr;
  logic [63:0] mmio_rd_data;

  modport master (
    output mmio_wr_en,
    output mmio_wr_addr,
    output mmio_wr_data,
    output mmio_rd_en,
    output mmio_rd_addr,
    input  mmio_rd_data
  );

  modport slave (
    input  mmio_wr_en,
    input  mmio_wr_addr,
    input  mmio_wr_data,
    input  mmio_rd_en,
    input  mmio_rd_addr,
    output mmio_rd_data
  );
endinterface

// File: rtl/dma_mmio_launcher.sv
// -----------------------------------------------------------------------------
// dma_mmio_launcher
// MMIO initiator for the DMA AFU memory map. On an accepted start it writes
// rd_addr (h0052), wr_addr (h0054) and size (h0056) back to back, writes go
// (h0050), then polls done (h0058) until bit0 is set or the poll budget runs
// out. Serves as a self-launching in-fabric harness.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   start       launch pulse, accepted only while idle
//   rd_addr_in  DMA source byte address (sampled at start acceptance)
//   wr_addr_in  DMA destination byte address (sampled at start acceptance)
//   size_in     cache lines to move (sampled at start acceptance)
//   busy        high from start acceptance until the completion slot
//   done        1-cycle pulse, DMA reported complete
//   error       1-cycle pulse in the completion slot: timeout or readback miss
//   mmio        dma_mmio_launcher_if.master, host side of the MMIO bus
//
// Optional feature: define MMIO_READBACK_EN to read back h0052/h0054/h0056
// after programming and abort (error, no go write) on any mismatch.
// -----------------------------------------------------------------------------
module dma_mmio_launcher #(
  parameter int unsigned ADDR_WIDTH = 32'd64,
  parameter int unsigned SIZE_WIDTH = 32'd16,
  parameter int unsigned RD_LATENCY = 32'd1,
  parameter int unsigned POLL_GAP   = 32'd8,
  parameter int unsigned TIMEOUT    = 32'd1048576
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [SIZE_WIDTH-1:0] size_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  dma_mmio_launcher_if.master   mmio
);

  // Register map of the DMA AFU
  localparam logic [15:0] REG_GO      = 16'h0050;
  localparam logic [15:0] REG_RD_ADDR = 16'h0052;
  localparam logic [15:0] REG_WR_ADDR = 16'h0054;
  localparam logic [15:0] REG_SIZE    = 16'h0056;
  localparam logic [15:0] REG_DONE    = 16'h0058;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WR_RA   = 4'd1;
  localparam logic [3:0] ST_WR_WA   = 4'd2;
  localparam logic [3:0] ST_WR_SZ   = 4'd3;
  localparam logic [3:0] ST_WR_GO   = 4'd4;
  localparam logic [3:0] ST_POLL_RD = 4'd5;
  localparam logic [3:0] ST_POLL_WT = 4'd6;
  localparam logic [3:0] ST_GAP     = 4'd7;
  localparam logic [3:0] ST_FINISH  = 4'd8;
`ifdef MMIO_READBACK_EN
  localparam logic [3:0] ST_RB_RD   = 4'd9;
  localparam logic [3:0] ST_RB_WT   = 4'd10;
`endif

  // Last cycle index of a read-latency wait / poll gap
  localparam logic [31:0] LAT_LAST = 32'(RD_LATENCY - 32'd1);
  localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 32'd1);

  logic [3:0]            state_r,     state_nx;
  logic [ADDR_WIDTH-1:0] rd_op_r,     rd_op_nx;
  logic [ADDR_WIDTH-1:0] wr_op_r,     wr_op_nx;
  logic [SIZE_WIDTH-1:0] size_op_r,   size_op_nx;
  logic [31:0]           poll_cnt_r,  poll_cnt_nx;
  logic [31:0]           wait_cnt_r,  wait_cnt_nx;
  logic                  err_flag_r,  err_flag_nx;
  logic                  wr_en_r,     wr_en_nx;
  logic [15:0]           wr_addr_r,   wr_addr_nx;
  logic [63:0]           wr_data_r,   wr_data_nx;
  logic                  rd_en_r,     rd_en_nx;
  logic [15:0]           rd_addr_r,   rd_addr_nx;
  logic                  busy_r,      busy_nx;
  logic                  done_r,      done_nx;
  logic                  error_r,     error_nx;
`ifdef MMIO_READBACK_EN
  logic [1:0]            rb_idx_r,    rb_idx_nx;
`else
  logic                  unused_rd_hi_s;
  assign unused_rd_hi_s = ^mmio.mmio_rd_data[63:1];
`endif

  function automatic logic [63:0] zext_addr(input logic [ADDR_WIDTH-1:0] a);
    zext_addr = 64'(a);
  endfunction

  function automatic logic [63:0] zext_size(input logic [SIZE_WIDTH-1:0] s);
    zext_size = 64'(s);
  endfunction

`ifdef MMIO_READBACK_EN
  function automatic logic [15:0] rb_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    rb_addr = REG_RD_ADDR;
      2'd1:    rb_addr = REG_WR_ADDR;
      default: rb_addr = REG_SIZE;
    endcase
  endfunction
`endif

  // Next-state, operand capture, counters and error flag
  always_comb begin
    state_nx    = state_r;
    rd_op_nx    = rd_op_r;
    wr_op_nx    = wr_op_r;
    size_op_nx  = size_op_r;
    poll_cnt_nx = poll_cnt_r;
    wait_cnt_nx = wait_cnt_r;
    err_flag_nx = err_flag_r;
`ifdef MMIO_READBACK_EN
    rb_idx_nx   = rb_idx_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          rd_op_nx    = rd_addr_in;
          wr_op_nx    = wr_addr_in;
          size_op_nx  = size_in;
          poll_cnt_nx = 32'd0;
          wait_cnt_nx = 32'd0;
          err_flag_nx = 1'b0;
          state_nx    = ST_WR_RA;
        end else begin
          state_nx    = ST_IDLE;
        end
      end
      ST_WR_RA: state_nx = ST_WR_WA;
      ST_WR_WA: state_nx = ST_WR_SZ;
      ST_WR_SZ: begin
`ifdef MMIO_READBACK_EN
        rb_idx_nx = 2'd0;
        state_nx  = ST_RB_RD;
`else
        state_nx  = ST_WR_GO;
`endif
      end
`ifdef MMIO_READBACK_EN
      ST_RB_RD: begin
        wait_cnt_nx = 32'd0;
        state_nx    = ST_RB_WT;
      end
      ST_RB_WT: begin
        if (wait_cnt_r == LAT_LAST) begin
          // Compare against the operand that was programmed at this index
          logic [63:0] exp_v;
          case (rb_idx_r)
            2'd0:    exp_v = zext_addr(rd_op_r);
            2'd1:    exp_v = zext_addr(wr_op_r);
            default: exp_v = zext_size(size_op_r);
          endcase
          if (mmio.mmio_rd_data != exp_v) begin
            err_flag_nx = 1'b1;
            state_nx    = ST_FINISH;
          end else if (rb_idx_r == 2'd2) begin
            state_nx    = ST_WR_GO;
          end else begin
            rb_idx_nx   = rb_idx_r + 2'd1;
            state_nx    = ST_RB_RD;
          end
        end else begin
          wait_cnt_nx = wait_cnt_r + 32'd1;
        end
      end
`endif
      ST_WR_GO: state_nx = ST_POLL_RD;
      ST_POLL_RD: begin
        if (poll_cnt_r != 32'hFFFF_FFFF) begin
          poll_cnt_nx = poll_cnt_r + 32'd1;
        end else begin
          poll_cnt_nx = poll_cnt_r;
        end
        wait_cnt_nx = 32'd0;
        state_nx    = ST_POLL_WT;
      end
      ST_POLL_WT: begin
        if (wait_cnt_r == LAT_LAST) begin
          if (mmio.mmio_rd_data[0]) begin
            state_nx    = ST_FINISH;
          end else if ((TIMEOUT != 32'd0) && (poll_cnt_r >= TIMEOUT)) begin
            // Poll budget spent with done still clear
            err_flag_nx = 1'b1;
            state_nx    = ST_FINISH;
          end else if (POLL_GAP == 32'd0) begin
            state_nx    = ST_POLL_RD;
          end else begin
            wait_cnt_nx = 32'd0;
            state_nx    = ST_GAP;
          end
        end else begin
          wait_cnt_nx = wait_cnt_r + 32'd1;
        end
      end
      ST_GAP: begin
        if (wait_cnt_r == GAP_LAST) begin
          state_nx    = ST_POLL_RD;
        end else begin
          wait_cnt_nx = wait_cnt_r + 32'd1;
        end
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output values are a function of the state being entered, so every
  // strobe lines up with its state while still coming from a flop
  always_comb begin
    wr_en_nx   = 1'b0;
    wr_addr_nx = wr_addr_r;
    wr_data_nx = wr_data_r;
    rd_en_nx   = 1'b0;
    rd_addr_nx = rd_addr_r;
    done_nx    = 1'b0;
    error_nx   = 1'b0;
    case (state_nx)
      ST_WR_RA: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = REG_RD_ADDR;
        wr_data_nx = zext_addr(rd_op_nx);
      end
      ST_WR_WA: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = REG_WR_ADDR;
        wr_data_nx = zext_addr(wr_op_nx);
      end
      ST_WR_SZ: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = REG_SIZE;
        wr_data_nx = zext_size(size_op_nx);
      end
      ST_WR_GO: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = REG_GO;
        wr_data_nx = 64'h1;
      end
`ifdef MMIO_READBACK_EN
      ST_RB_RD: begin
        rd_en_nx   = 1'b1;
        rd_addr_nx = rb_addr(rb_idx_nx);
      end
`endif
      ST_POLL_RD: begin
        rd_en_nx   = 1'b1;
        rd_addr_nx = REG_DONE;
      end
      ST_FINISH: begin
        done_nx    = ~err_flag_nx;
        error_nx   = err_flag_nx;
      end
      default: begin
        wr_en_nx   = 1'b0;
        rd_en_nx   = 1'b0;
      end
    endcase
  end

  // busy drops in the completion slot so it falls together with done/error
  assign busy_nx = (state_nx != ST_IDLE) && (state_nx != ST_FINISH);

  // State, operand and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      rd_op_r    <= '0;
      wr_op_r    <= '0;
      size_op_r  <= '0;
      poll_cnt_r <= 32'd0;
      wait_cnt_r <= 32'd0;
      err_flag_r <= 1'b0;
`ifdef MMIO_READBACK_EN
      rb_idx_r   <= 2'd0;
`endif
    end else begin
      state_r    <= state_nx;
      rd_op_r    <= rd_op_nx;
      wr_op_r    <= wr_op_nx;
      size_op_r  <= size_op_nx;
      poll_cnt_r <= poll_cnt_nx;
      wait_cnt_r <= wait_cnt_nx;
      err_flag_r <= err_flag_nx;
`ifdef MMIO_READBACK_EN
      rb_idx_r   <= rb_idx_nx;
`endif
    end
  end

  // Output registers; reset clears everything so an abort leaves no MMIO cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= 16'd0;
      wr_data_r <= 64'd0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= 16'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      wr_en_r   <= wr_en_nx;
      wr_addr_r <= wr_addr_nx;
      wr_data_r <= wr_data_nx;
      rd_en_r   <= rd_en_nx;
      rd_addr_r <= rd_addr_nx;
      busy_r    <= busy_nx;
      done_r    <= done_nx;
      error_r   <= error_nx;
    end
  end

  assign mmio.mmio_wr_en   = wr_en_r;
  assign mmio.mmio_wr_addr = wr_addr_r;
  assign mmio.mmio_wr_data = wr_data_r;
  assign mmio.mmio_rd_en   = rd_en_r;
  assign mmio.mmio_rd_addr = rd_addr_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign error             = error_r;

endmodule

// File: tb/tb_dma_mmio_launcher.sv
// -----------------------------------------------------------------------------
// tb_dma_mmio_launcher
// Drives dma_mmio_launcher against a behavioural MMIO register responder and
// checks the observed MMIO/handshake trace against a timeline computed from
// the launcher's programming and polling rules.
// -----------------------------------------------------------------------------
module tb_dma_mmio_launcher;
  localparam int RDL = 2;   // read latency
  localparam int GAP = 3;   // idle cycles between polls
  localparam int TMO = 5;   // poll budget

  typedef struct {
    int          cyc;
    bit          wr;
    logic [15:0] addr;
    logic [63:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] rd_addr_in = 64'd0;
  logic [63:0] wr_addr_in = 64'd0;
  logic [15:0] size_in = 16'd0;
  logic        busy, done, error;

  dma_mmio_launcher_if mif ();

  dma_mmio_launcher #(
    .ADDR_WIDTH(64), .SIZE_WIDTH(16), .RD_LATENCY(RDL), .POLL_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rd_addr_in(rd_addr_in), .wr_addr_in(wr_addr_in), .size_in(size_in),
    .busy(busy), .done(done), .error(error), .mmio(mif)
  );

  always #5 clk = ~clk;

  // ---------------- responder: register file + latency pipe ----------------
  logic [63:0] reg_ra = 64'd0, reg_wa = 64'd0, reg_sz = 64'd0;
  logic [63:0] noise = 64'd0;
  logic [63:0] dly [RDL];
  logic [63:0] rd_val_s;
  int          total_polls = 0;
  int          done_at = 1;
  bit          corrupt_rb = 1'b0;

  always_comb begin
    rd_val_s = 64'd0;
    if (mif.mmio_rd_en) begin
      case (mif.mmio_rd_addr)
        16'h0052: rd_val_s = reg_ra;
        16'h0054: rd_val_s = corrupt_rb ? reg_wa + 64'd64 : reg_wa;
        16'h0056: rd_val_s = reg_sz;
        16'h0058: rd_val_s = {noise[63:1], (total_polls + 1 >= done_at)};
        default:  rd_val_s = 64'd0;
      endcase
    end
  end

  always @(posedge clk) begin
    noise <= {$urandom, $urandom};
    dly[0] <= rd_val_s;
    for (int i = 1; i < RDL; i++) dly[i] <= dly[i-1];
    if (mif.mmio_rd_en && mif.mmio_rd_addr == 16'h0058) total_polls <= total_polls + 1;
    if (mif.mmio_wr_en) begin
      case (mif.mmio_wr_addr)
        16'h0052: reg_ra <= mif.mmio_wr_data;
        16'h0054: reg_wa <= mif.mmio_wr_data;
        16'h0056: reg_sz <= mif.mmio_wr_data;
        default:  ;
      endcase
    end
  end
  assign mif.mmio_rd_data = dly[RDL-1];

  // ---------------- monitor ----------------
  int   cyc = 0;
  ev_t  ev_q[$];
  int   fin_cyc_q[$];
  bit   fin_done_q[$], fin_err_q[$], fin_busy_q[$];
  bit   overlap_seen = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mif.mmio_wr_en && mif.mmio_rd_en) overlap_seen <= 1'b1;
    if (mif.mmio_wr_en) ev_q.push_back('{cyc: cyc, wr: 1'b1, addr: mif.mmio_wr_addr, data: mif.mmio_wr_data});
    if (mif.mmio_rd_en) ev_q.push_back('{cyc: cyc, wr: 1'b0, addr: mif.mmio_rd_addr, data: 64'd0});
    if (done || error) begin
      fin_cyc_q.push_back(cyc);
      fin_done_q.push_back(done);
      fin_err_q.push_back(error);
      fin_busy_q.push_back(busy);
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ".busy"},    busy, 1'b0);
    chk({tag, ".done"},    done, 1'b0);
    chk({tag, ".error"},   error, 1'b0);
    chk({tag, ".wr_en"},   mif.mmio_wr_en, 1'b0);
    chk({tag, ".wr_addr"}, mif.mmio_wr_addr, 16'd0);
    chk({tag, ".wr_data"}, mif.mmio_wr_data, 64'd0);
    chk({tag, ".rd_en"},   mif.mmio_rd_en, 1'b0);
    chk({tag, ".rd_addr"}, mif.mmio_rd_addr, 16'd0);
  endtask

  // One launch: drive start, optionally poke start mid-poll, then compare the
  // trace against the timeline implied by the launcher's rules.
  task automatic run_txn(input string name, input logic [63:0] rd, input logic [63:0] wr,
                         input logic [15:0] sz, input int n_done, input bit corrupt, input bit poke);
    int  ev_base, fin_base, s, t, fin_c, n;
    bit  exp_err, rb_fail, found;
    ev_t exp_q[$];

    ev_base  = ev_q.size();
    fin_base = fin_cyc_q.size();
    done_at  = total_polls + n_done;
    corrupt_rb = corrupt;

    @(negedge clk);
    rd_addr_in = rd; wr_addr_in = wr; size_in = sz; start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
    rd_addr_in = ~rd; wr_addr_in = ~wr; size_in = ~sz;
    chk({name, ".busy_after_start"}, busy, 1'b1);

    if (poke) begin
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
        @(negedge clk);
        if (mif.mmio_rd_en && mif.mmio_rd_addr == 16'h0058) found = 1'b1;
      end
      chk({name, ".poll_seen"}, found, 1'b1);
      @(negedge clk);   // first POLL_WT cycle
      rd_addr_in = 64'hDEAD_0000; wr_addr_in = 64'hBEEF_0000; size_in = 16'h77; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end

    for (int i = 0; i < 400 && fin_cyc_q.size() == fin_base; i++) @(negedge clk);
    repeat (4) @(negedge clk);

    // expected timeline
    exp_q.push_back('{cyc: s + 1, wr: 1'b1, addr: 16'h0052, data: rd});
    exp_q.push_back('{cyc: s + 2, wr: 1'b1, addr: 16'h0054, data: wr});
    exp_q.push_back('{cyc: s + 3, wr: 1'b1, addr: 16'h0056, data: {48'd0, sz}});
    t = s + 4;
    rb_fail = 1'b0;
    fin_c = 0;
    exp_err = 1'b0;
`ifdef MMIO_READBACK_EN
    for (int i = 0; i < 3 && !rb_fail; i++) begin
      exp_q.push_back('{cyc: t, wr: 1'b0, addr: 16'h0052 + 16'(2 * i), data: 64'd0});
      if (i == 1 && corrupt) begin
        rb_fail = 1'b1;
        exp_err = 1'b1;
        fin_c   = t + RDL + 1;
      end
      t = t + 1 + RDL;
    end
`endif
    if (!rb_fail) begin
      exp_q.push_back('{cyc: t, wr: 1'b1, addr: 16'h0050, data: 64'd1});
      t = t + 1;
      exp_err = (TMO != 0) && (n_done > TMO);
      n = exp_err ? TMO : n_done;
      for (int k = 0; k < n; k++)
        exp_q.push_back('{cyc: t + k * (1 + RDL + GAP), wr: 1'b0, addr: 16'h0058, data: 64'd0});
      fin_c = t + (n - 1) * (1 + RDL + GAP) + RDL + 1;
    end

    chk({name, ".mmio_count"}, 64'(ev_q.size() - ev_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && ev_base + i < ev_q.size(); i++) begin
      chk($sformatf("%s.ev%0d.cyc", name, i),  64'(ev_q[ev_base+i].cyc), 64'(exp_q[i].cyc));
      chk($sformatf("%s.ev%0d.wr", name, i),   ev_q[ev_base+i].wr,   exp_q[i].wr);
      chk($sformatf("%s.ev%0d.addr", name, i), ev_q[ev_base+i].addr, exp_q[i].addr);
      chk($sformatf("%s.ev%0d.data", name, i), ev_q[ev_base+i].data, exp_q[i].data);
    end
    chk({name, ".fin_count"}, 64'(fin_cyc_q.size() - fin_base), 64'd1);
    if (fin_cyc_q.size() > fin_base) begin
      chk({name, ".fin_cyc"},   64'(fin_cyc_q[fin_base]), 64'(fin_c));
      chk({name, ".done"},      fin_done_q[fin_base], !exp_err);
      chk({name, ".error"},     fin_err_q[fin_base], exp_err);
      chk({name, ".busy_fin"},  fin_busy_q[fin_base], 1'b0);
    end
    chk({name, ".idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    bit found;
    // reset state
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // program sequence + poll to completion (3 zero polls, then done)
    run_txn("t1_prog", 64'h1000, 64'h2000, 16'd4, 4, 1'b0, 1'b0);
    // done on the very first poll, size 0 programmed as-is
    run_txn("t1_size0", 64'h40, 64'h80, 16'd0, 1, 1'b0, 1'b0);
    // done on the last allowed poll
    run_txn("t2_edge", 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 16'hFFFF, TMO, 1'b0, 1'b0);
    // timeout with done stuck at 0
    run_txn("t3_tmo", 64'h3000, 64'h4000, 16'd8, 1000, 1'b0, 1'b0);
    // start ignored while polling
    run_txn("t4_busy", 64'h5000, 64'h6000, 16'd2, 3, 1'b0, 1'b1);

    // async reset between rd_en and data return
    done_at = total_polls + 1000;
    @(negedge clk);
    rd_addr_in = 64'h7000; wr_addr_in = 64'h8000; size_in = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (mif.mmio_rd_en && mif.mmio_rd_addr == 16'h0058) found = 1'b1;
    end
    chk("t5.poll_seen", found, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("t5_abort");
    repeat (2) @(negedge clk);
    chk_outputs_zero("t5_held");
    rst_n = 1'b1;
    @(negedge clk);
    run_txn("t5_rerun", 64'h1000, 64'h2000, 16'd4, 4, 1'b0, 1'b0);

`ifdef MMIO_READBACK_EN
    run_txn("t6_rb_miss", 64'h1000, 64'h2000, 16'd4, 2, 1'b1, 1'b0);
`endif

    // randomized launches
    for (int r = 0; r < 6; r++) begin
      run_txn($sformatf("rand%0d", r), {$urandom, $urandom}, {$urandom, $urandom},
              16'($urandom_range(0, 65535)), int'($urandom_range(1, TMO + 2)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk("no_wr_rd_overlap", overlap_seen, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
